// File: rtl/ifetch_unit_if.sv
// Fetch-to-decode handshake bundle for ifetch_unit.
// master: fetch stage (drives the buffer head), slave: decode stage.
interface ifetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic            out_misalign;

  modport master (
    output out_valid, out_instr, out_pc, out_pc_plus4, out_misalign,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_pc, out_pc_plus4, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch stage: owns the PC, reads the combinational
// instruction ROM and queues {pc, instr, misalign} in an in-order buffer
// toward decode. Execute-stage redirects flush the buffer and reload the PC.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// target produces one faulting NOP entry and halts fetch until the next
// aligned redirect; without it, redirect targets are forced to word alignment.
module ifetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  ifetch_unit_if.master   dec
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];

  logic            head_valid;
  logic            pop;
  logic            push;
  logic [31:0]     wr_instr;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic            mis_mem_q [DEPTH];
  logic            wr_mis;
`endif

  // Head handshake, push decision and next-state for pc/pointers/count
  always_comb begin
    head_valid = (cnt_q != '0) && !redirect_valid;
    pop        = head_valid && dec.out_ready;
    push       = 1'b0;
    wr_instr   = imem_rdata;
    pc_d       = pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    halted_d   = halted_q;
    fault_d    = fault_q;
    wr_mis     = 1'b0;
`endif
    if (redirect_valid) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_d     = redirect_pc;
      halted_d = (redirect_pc[1:0] != 2'b00);
      fault_d  = (redirect_pc[1:0] != 2'b00);
`else
      pc_d = redirect_pc & ~XLEN'(3);
`endif
    end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      // The fault entry lands right after the flushing redirect, so the
      // buffer is empty and always has room; pc stays at the faulting address.
      if (fault_q) begin
        push     = 1'b1;
        wr_instr = NOP;
        wr_mis   = 1'b1;
        fault_d  = 1'b0;
      end else if (!halted_q && ((cnt_q < CW'(DEPTH)) || pop)) begin
        push = 1'b1;
        pc_d = pc_q + XLEN'(4);
      end
`else
      if ((cnt_q < CW'(DEPTH)) || pop) begin
        push = 1'b1;
        pc_d = pc_q + XLEN'(4);
      end
`endif
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state: pc, pointers, occupancy, halt/fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_q <= halted_d;
      fault_q  <= fault_d;
`endif
    end
  end

  // Buffer storage: every entry reset to a NOP at PC 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= NOP;
`ifdef IFETCH_MISALIGN_TRAP_EN
        mis_mem_q[i] <= 1'b0;
`endif
      end
    end else if (push) begin
      pc_mem_q[wr_q]  <= pc_q;
      ins_mem_q[wr_q] <= wr_instr;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_mem_q[wr_q] <= wr_mis;
`endif
    end
  end

  assign imem_addr        = pc_q;
  assign dec.out_valid    = head_valid;
  assign dec.out_instr    = ins_mem_q[rd_q];
  assign dec.out_pc       = pc_mem_q[rd_q];
  assign dec.out_pc_plus4 = pc_mem_q[rd_q] + XLEN'(4);
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign dec.out_misalign = mis_mem_q[rd_q];
`else
  assign dec.out_misalign = 1'b0;
`endif

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the RV32I pipeline. It owns the program counter, drives the byte address into the combinational-read instruction ROM, and captures the returned word together with its PC. Fetched words go into a small in-order buffer that feeds decode over a valid/ready handshake. It accepts control-flow redirects (branch, jump) from the execute stage; a redirect flushes everything already fetched and not yet accepted by decode.

## Interface
Parameters:
- XLEN, riscv_pkg::XLEN (32): PC and address width.
- RESET_PC, 0: PC value loaded on reset.
- DEPTH, 2: fetch buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  XLEN  byte address to the instruction ROM; equals the PC register.
- imem_rdata  in  32  instruction word; combinational function of imem_addr, valid in the same cycle.
- redirect_valid  in  1  execute-stage redirect request.
- redirect_pc  in  XLEN  redirect target byte address.
- out_valid  out  1  buffer head is valid toward decode.
- out_ready  in  1  decode accepts the head; low means stall.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_pc_plus4  out  XLEN  head PC + 4, modulo 2^XLEN.
- out_misalign  out  1  head carries a misaligned-fetch fault (see Configuration).

## Operation
- State: pc register, halted flag, DEPTH-entry FIFO of {pc, instr, misalign}, read/write pointers, and a count from 0 to DEPTH.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halted & (count < DEPTH | pop).
- On push, write {pc, imem_rdata, 0} at the tail and update pc <= pc + 4, wrapping at 2^XLEN.
- Push and pop may occur in the same cycle, including when the buffer is full. Count is then unchanged.
- out_valid = (count != 0) & !redirect_valid. A redirect combinationally masks the head, so decode can never accept a stale word in the redirect cycle.
- Redirect has top priority:
  - count <= 0 and pointers reset.
  - pc <= redirect_pc.
  - No push that cycle; any pop that cycle is discarded.
  - halted is cleared or set as described under Configuration.
- The head outputs are read directly from the FIFO storage. out_pc_plus4 is computed combinationally from out_pc.
- Entries leave in fetch order. No reordering and no duplication.

## Timing
- Reset, asynchronous and immediate:
  - pc = RESET_PC, count = 0, halted = 0.
  - Every storage entry is set to {0, 0x00000013 (NOP), 0}.
  - Outputs during reset: imem_addr = RESET_PC, out_valid = 0, out_instr = 0x00000013, out_pc = 0, out_pc_plus4 = 4, out_misalign = 0.
- Reset asserted mid-stream drops all buffered entries with no partial output.
- First fetch happens at the first rising edge after rst_n deasserts. out_valid rises one cycle later with out_pc = RESET_PC.
- Fetch-to-decode latency is 1 cycle when the buffer is empty and out_ready is held high.
- Sustained throughput is 1 instruction per cycle.
- Redirect sampled at edge k:
  - imem_addr = target during cycle k+1.
  - out_valid with out_pc = target in cycle k+2.
  - Redirect penalty is 2 cycles.
- With out_ready held low, the buffer fills to DEPTH and then stops fetching. pc holds, so imem_addr is stable.
- A back-to-back redirect in consecutive cycles takes the last target.

## Configuration
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined, and redirect_pc[1:0] != 0:
  - pc loads redirect_pc unmodified and halted <= 1.
  - On the next edge, exactly one entry {pc, 0x00000013, 1} is pushed, so decode receives out_misalign = 1 with the faulting PC.
  - No further fetches occur until the next aligned redirect. Reset also clears the halt.
- Not defined:
  - pc loads {redirect_pc[XLEN-1:2], 2'b00}.
  - halted is never set and out_misalign is tied to 0.

## Test plan
- Reset release, ROM preloaded with addi x1..x10, out_ready = 1 -> out_pc reads 0x00, 0x04, … 0x24 on consecutive cycles; out_instr reads 0x00100093, 0x00200113, …; out_pc_plus4 = out_pc + 4.
- out_ready low for 5 cycles starting at PC 0x08 -> count saturates at 2 and imem_addr holds at 0x10; after release, 0x08 and 0x0C are delivered, then 0x10, with no gaps or duplicates.
- Redirect to 0x40 while 2 entries are buffered and out_ready = 1 -> out_valid = 0 in the redirect cycle, stale 0x08/0x0C are never accepted, and the next accepted out_pc is 0x40 two cycles later.
- Redirect to 0x41:
  - Macro defined -> one entry with out_misalign = 1 and out_pc = 0x41, then out_valid stays 0 until a redirect to 0x80.
  - Macro undefined -> fetch resumes at 0x40.
- rst_n pulsed low mid-stream with a full buffer -> out_valid drops immediately and out_instr = 0x00000013; fetch restarts at RESET_PC.
- RESET_PC = 0xFFFFFFFC -> the second fetch is 0x00000000 (wrap); out_pc_plus4 of the first entry = 0x00000000.
